// File: rtl/perf_counter_reader.sv
// perf_counter_reader: NUM_EVENTS wrapping event counters, with single indexed
// reads and a snapshot-based sequential dump served over a valid/ready port.
module perf_counter_reader #(
  parameter int unsigned NUM_EVENTS = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  freeze_i,
  input  logic                  clear_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IDX_WIDTH-1:0]  req_idx,
  input  logic                  dump_start,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [CNT_WIDTH-1:0]  resp_data,
  output logic [IDX_WIDTH-1:0]  resp_idx,
  output logic                  resp_err,
  output logic                  resp_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd1,
    S_DUMP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q  [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] cnt_d  [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] snap_q [NUM_EVENTS];
  logic                 snap_load;

  logic                 resp_valid_q, resp_valid_d;
  logic [CNT_WIDTH-1:0] resp_data_q,  resp_data_d;
  logic [IDX_WIDTH-1:0] resp_idx_q,   resp_idx_d;
  logic                 resp_err_q,   resp_err_d;
  logic                 resp_last_q,  resp_last_d;
  logic                 busy_q,       busy_d;

  logic                 idx_ok;
  logic [CNT_WIDTH-1:0] rd_val;
  logic [IDX_WIDTH-1:0] next_idx;

  // Non power-of-two counts leave index codes that map to no counter.
  assign idx_ok   = (32'(req_idx) < NUM_EVENTS);
  assign rd_val   = idx_ok ? cnt_q[req_idx] : '0;
  assign next_idx = resp_idx_q + IDX_WIDTH'(1);

  // Live counter update: clear wins over events, freeze drops events.
  always_comb begin
    for (int i = 0; i < int'(NUM_EVENTS); i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_i) begin
        cnt_d[i] = '0;
      end else if (event_i[i] && !freeze_i) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Live counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_EVENTS); i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Dump snapshot; a same-cycle clear is folded in so the dump sees zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_EVENTS); i++) snap_q[i] <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < int'(NUM_EVENTS); i++) snap_q[i] <= clear_i ? '0 : cnt_q[i];
    end
  end

  // Next-state and response register inputs; resp_idx doubles as the dump beat index.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_idx_d   = resp_idx_q;
    resp_err_d   = resp_err_q;
    resp_last_d  = resp_last_q;
    busy_d       = busy_q;
    snap_load    = 1'b0;
    req_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = !dump_start;
        if (dump_start) begin
          snap_load    = 1'b1;
          state_d      = S_DUMP;
          busy_d       = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = clear_i ? '0 : cnt_q[0];
          resp_idx_d   = '0;
          resp_err_d   = 1'b0;
          resp_last_d  = 1'b0;
        end else if (req_valid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = rd_val;
          resp_idx_d   = req_idx;
          resp_err_d   = !idx_ok;
          resp_last_d  = 1'b0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_DUMP: begin
        if (resp_ready) begin
          if (resp_last_q) begin
            resp_valid_d = 1'b0;
            resp_last_d  = 1'b0;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
          end else begin
            resp_data_d  = snap_q[next_idx];
            resp_idx_d   = next_idx;
            resp_last_d  = (next_idx == IDX_WIDTH'(NUM_EVENTS - 1));
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_idx_q   <= '0;
      resp_err_q   <= 1'b0;
      resp_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_idx_q   <= resp_idx_d;
      resp_err_q   <= resp_err_d;
      resp_last_q  <= resp_last_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_idx   = resp_idx_q;
  assign resp_err   = resp_err_q;
  assign resp_last  = resp_last_q;
  assign busy       = busy_q;

endmodule
